// File: rtl/core_array_pkg.sv
// core_array_pkg: shared types and constants for the core array feeder.
// Holds the feeder state encoding, the column index type and array sizes.
package core_array_pkg;

    localparam int DATA_SIZE_DEFAULT = 8;
    localparam int NUM_COLS          = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2
    } feeder_state_e;

    typedef logic col_t;

    localparam col_t COL1 = 1'b0;
    localparam col_t COL2 = 1'b1;

endpackage

// File: rtl/core_array_gap_cnt.sv
// core_array_gap_cnt: loadable down-counter with zero flag.
// Enforces the minimum idle spacing between fills on one column.
module core_array_gap_cnt
    import core_array_pkg::*;
#(
    parameter int mask_cnt_delay = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    localparam int W = (mask_cnt_delay > 0) ? $clog2(mask_cnt_delay + 1) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(mask_cnt_delay);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/core_array_feeder.sv
// core_array_feeder: deals a valid/ready word stream round-robin into the two
// north column ports of the core array. CORE_ARRAY_FEEDER_STALL_CNT_EN adds stall_cnt.
module core_array_feeder
    import core_array_pkg::*;
#(
    parameter int data_size      = DATA_SIZE_DEFAULT,
    parameter int col_depth      = 4,
    parameter int mask_cnt_delay = 1,
    parameter int settle_cycles  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 s_valid,
    input  logic [data_size-1:0] s_data,
    output logic                 s_ready,
    output logic [data_size-1:0] o_data1,
    output logic                 o_fill1,
    output logic [data_size-1:0] o_data2,
    output logic                 o_fill2,
    output logic                 busy,
    output logic                 done
`ifdef CORE_ARRAY_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int WORDS = 2 * col_depth;
    localparam int CW    = $clog2(WORDS + 1);
    localparam int SW    = $clog2(settle_cycles + 1);

    localparam logic [CW-1:0] LAST_CNT    = CW'(WORDS - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(settle_cycles);

    feeder_state_e state_q, state_d;
    col_t          ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          done_q, done_d;

    logic                 fill1_q, fill1_d;
    logic                 fill2_q, fill2_d;
    logic [data_size-1:0] data1_q, data1_d;
    logic [data_size-1:0] data2_q, data2_d;

    logic [NUM_COLS-1:0] gap_zero;
    logic                accept;

    // abort gates ready so no word is taken in the cycle the frame is cancelled
    assign s_ready = (state_q == LOAD) && !abort && gap_zero[ptr_q];
    assign accept  = s_valid && s_ready;

    for (genvar i = 0; i < NUM_COLS; i++) begin : g_gap
        core_array_gap_cnt #(
            .mask_cnt_delay(mask_cnt_delay)
        ) u_gap (
            .clk  (clk),
            .rst_n(rst_n),
            .load (accept && (ptr_q == col_t'(i))),
            .zero (gap_zero[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = LOAD;
                    ptr_d   = COL1;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    ptr_d = ~ptr_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d  = SETTLE;
                        settle_d = SETTLE_LOAD;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d  = IDLE;
                    settle_d = '0;
                end else if (settle_q <= SW'(1)) begin
                    state_d  = IDLE;
                    settle_d = '0;
                    done_d   = 1'b1;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        fill1_d = accept && (ptr_q == COL1);
        fill2_d = accept && (ptr_q == COL2);
        data1_d = fill1_d ? s_data : data1_q;
        data2_d = fill2_d ? s_data : data2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= COL1;
            cnt_q    <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
            fill1_q  <= 1'b0;
            fill2_q  <= 1'b0;
            data1_q  <= '0;
            data2_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            fill1_q  <= fill1_d;
            fill2_q  <= fill2_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
        end
    end

`ifdef CORE_ARRAY_FEEDER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start && !abort) begin
            stall_d = '0;
        end else if (state_q == LOAD && s_valid && !s_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign o_fill1 = fill1_q;
    assign o_fill2 = fill2_q;
    assign o_data1 = data1_q;
    assign o_data2 = data2_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_core_array_feeder.sv
// tb_core_array_feeder: two feeders (mask delay 1 and 2) on shared stimulus,
// checked every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_core_array_feeder;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 4;
    localparam int MASK0  = 1;
    localparam int MASK1  = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       s_valid;
    logic [7:0] s_data;

    logic [1:0] rdy_w, f1_w, f2_w, busy_w, done_w;
    logic [7:0] d1_w [2];
    logic [7:0] d2_w [2];
`ifdef CORE_ARRAY_FEEDER_STALL_CNT_EN
    logic [15:0] st_w [2];
`endif

    core_array_feeder #(
        .data_size(8), .col_depth(DEPTH), .mask_cnt_delay(MASK0), .settle_cycles(SETTLE)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_w[0]),
        .o_data1(d1_w[0]), .o_fill1(f1_w[0]), .o_data2(d2_w[0]), .o_fill2(f2_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
`ifdef CORE_ARRAY_FEEDER_STALL_CNT_EN
        , .stall_cnt(st_w[0])
`endif
    );

    core_array_feeder #(
        .data_size(8), .col_depth(DEPTH), .mask_cnt_delay(MASK1), .settle_cycles(SETTLE)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_w[1]),
        .o_data1(d1_w[1]), .o_fill1(f1_w[1]), .o_data2(d2_w[1]), .o_fill2(f2_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
`ifdef CORE_ARRAY_FEEDER_STALL_CNT_EN
        , .stall_cnt(st_w[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: 0 idle, 1 loading, 2 settling
    int          m_state [2];
    int          m_n [2];
    int          m_done_at [2];
    int          m_last [2][2];
    logic        m_f1 [2];
    logic        m_f2 [2];
    logic        m_done [2];
    logic [7:0]  m_d1 [2];
    logic [7:0]  m_d2 [2];
    logic [15:0] m_stall [2];
    int          cyc;
    int          total;
    int          bad;

    function automatic logic exp_ready(int k);
        int m = (k == 0) ? MASK0 : MASK1;
        return (m_state[k] == 1) && !abort
            && ((cyc - m_last[k][m_n[k] % 2]) > m);
    endfunction

    function automatic logic [36:0] expv(int k);
        logic [15:0] st = 16'h0;
`ifdef CORE_ARRAY_FEEDER_STALL_CNT_EN
        st = m_stall[k];
`endif
        return {exp_ready(k), m_state[k] != 0, m_done[k],
                m_f1[k], m_d1[k], m_f2[k], m_d2[k], st};
    endfunction

    function automatic logic [36:0] obs(int k);
        logic [15:0] st = 16'h0;
`ifdef CORE_ARRAY_FEEDER_STALL_CNT_EN
        st = st_w[k];
`endif
        return {rdy_w[k], busy_w[k], done_w[k],
                f1_w[k], d1_w[k], f2_w[k], d2_w[k], st};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_n[k] = 0; m_done_at[k] = 0;
            m_last[k][0] = -100; m_last[k][1] = -100;
            m_f1[k] = 0; m_f2[k] = 0; m_done[k] = 0;
            m_d1[k] = 0; m_d2[k] = 0; m_stall[k] = 0;
        end
    endtask

    // advance the model across the coming rising edge using current inputs
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic rdy = exp_ready(k);
            logic acc = s_valid && rdy;
            int   col = m_n[k] % 2;
            m_f1[k] = 0; m_f2[k] = 0; m_done[k] = 0;
            if (m_state[k] == 1 && s_valid && !rdy && m_stall[k] != 16'hFFFF)
                m_stall[k] = m_stall[k] + 16'd1;
            if (acc) begin
                if (col == 0) begin m_f1[k] = 1; m_d1[k] = s_data; end
                else begin m_f2[k] = 1; m_d2[k] = s_data; end
                m_last[k][col] = cyc;
                m_n[k]++;
            end
            case (m_state[k])
                0: if (start && !abort) begin
                    m_state[k] = 1; m_n[k] = 0; m_stall[k] = 0;
                end
                1: if (abort) m_state[k] = 0;
                   else if (m_n[k] == 2 * DEPTH) begin
                       m_state[k] = 2; m_done_at[k] = cyc + SETTLE + 1;
                   end
                default: if (abort) m_state[k] = 0;
                   else if (cyc + 1 == m_done_at[k]) begin
                       m_state[k] = 0; m_done[k] = 1;
                   end
            endcase
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b1; abort = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs(k) !== expv(k)) begin
                bad++;
                $display("FAIL reset dut%0d got=%h exp=%h", k, obs(k), expv(k));
            end
        end
        start = 1'b0; s_valid = 1'b0;
        rst_n = 1'b1;
        model_edge();
    endtask

    task automatic test_stream();
        logic [7:0] q1 [$];
        logic [7:0] q2 [$];
        int lf0 = -1000, dc0 = -1, min_gap = 1000;
        int pf [2] = '{-1, -1};
        logic fin = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start = (c == 0); abort = 0; s_valid = 1;
            s_data = 8'h10 + 8'(m_n[0]);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL stream dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), expv(k));
                end
            end
            if (f1_w[0]) q1.push_back(d1_w[0]);
            if (f2_w[0]) q2.push_back(d2_w[0]);
            if (f1_w[0] || f2_w[0]) lf0 = cyc;
            if (done_w[0]) dc0 = cyc;
            for (int col = 0; col < 2; col++) begin
                if ((col == 0) ? f1_w[1] : f2_w[1]) begin
                    if (pf[col] >= 0 && cyc - pf[col] < min_gap) min_gap = cyc - pf[col];
                    pf[col] = cyc;
                end
            end
            fin = (c > 0) && m_state[0] == 0 && m_state[1] == 0;
            model_edge();
            if (fin) break;
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL stream_timeout got=busy exp=idle");
        end
        total++;
        if (q1.size() != DEPTH || q2.size() != DEPTH) begin
            bad++;
            $display("FAIL stream_count got=%0d/%0d exp=%0d", q1.size(), q2.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (i >= q1.size() || i >= q2.size()
                || q1[i] !== 8'(16 + 2 * i) || q2[i] !== 8'(17 + 2 * i)) begin
                bad++;
                $display("FAIL stream_order idx=%0d exp=%h/%h", i, 8'(16 + 2 * i), 8'(17 + 2 * i));
            end
        end
        total++;
        if (dc0 - lf0 != SETTLE) begin
            bad++;
            $display("FAIL settle_delay got=%0d exp=%0d", dc0 - lf0, SETTLE);
        end
        total++;
        if (min_gap != MASK1 + 1) begin
            bad++;
            $display("FAIL fill_spacing got=%0d exp=%0d", min_gap, MASK1 + 1);
        end
    endtask

    task automatic test_valid_toggle();
        logic fin = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = (c == 0); abort = 0; s_valid = c[0];
            s_data = 8'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL toggle dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), expv(k));
                end
            end
            fin = (c > 0) && m_state[0] == 0 && m_state[1] == 0;
            model_edge();
            if (fin) break;
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL toggle_timeout got=busy exp=idle");
        end
    endtask

    task automatic test_abort();
        int ab_c = -10;
        int dones = 0;
        logic fin = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            abort = (ab_c < 0) && m_state[0] == 1 && m_n[0] == 3;
            if (abort) ab_c = c;
            start = (c == 0) || (ab_c >= 0 && c == ab_c + 2);
            s_valid = 1; s_data = 8'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL abort dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), expv(k));
                end
            end
            if (abort) begin
                total++;
                if (rdy_w[0] !== 1'b0 || f1_w[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL abort_cycle got=rdy%b/fill%b exp=rdy0/fill1", rdy_w[0], f1_w[0]);
                end
            end
            if (ab_c >= 0 && c > ab_c && c <= ab_c + 2 && (done_w != 2'b00 || busy_w != 2'b00))
                dones++;
            fin = (ab_c >= 0) && (c > ab_c + 2) && m_state[0] == 0 && m_state[1] == 0;
            model_edge();
            if (fin) break;
        end
        total++;
        if (!fin || dones != 0) begin
            bad++;
            $display("FAIL abort_idle got=fin%0d/busy_or_done%0d exp=fin1/0", fin, dones);
        end
    endtask

    task automatic test_reset_settle();
        logic hit = 0;
        logic fin = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = (c == 0); abort = 0;
            s_valid = ($urandom_range(0, 3) != 0); s_data = 8'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL rst_pre dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), expv(k));
                end
            end
            model_edge();
            if (m_state[0] == 2) begin hit = 1; break; end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rst_settle_reach got=0 exp=1");
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL rst_async dut%0d got=%h exp=%h", k, obs(k), expv(k));
                end
            end
            if (r == 0) begin @(negedge clk); #1; end
        end
        start = 0; s_valid = 0; abort = 0;
        rst_n = 1'b1;
        model_edge();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = (c == 0); abort = 0; s_valid = 1; s_data = 8'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL rst_post dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), expv(k));
                end
            end
            fin = (c > 0) && m_state[0] == 0 && m_state[1] == 0;
            model_edge();
            if (fin) break;
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL rst_post_timeout got=busy exp=idle");
        end
    endtask

    task automatic test_back_to_back();
        logic fin = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            start = (c < 60); abort = (c == 0);
            s_valid = ($urandom_range(0, 4) != 0); s_data = 8'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL b2b dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), expv(k));
                end
            end
            if (c == 1) begin
                total++;
                if (busy_w !== 2'b00) begin
                    bad++;
                    $display("FAIL start_abort_idle got=%b exp=00", busy_w);
                end
            end
            fin = (c >= 60) && m_state[0] == 0 && m_state[1] == 0;
            model_edge();
            if (fin) break;
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL b2b_timeout got=busy exp=idle");
        end
    endtask

    task automatic test_random();
        logic fin = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            start   = (c < 500) && ($urandom_range(0, 7) == 0);
            abort   = (c < 500) && ($urandom_range(0, 39) == 0);
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = 8'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), expv(k));
                end
            end
            fin = (c >= 500) && m_state[0] == 0 && m_state[1] == 0;
            model_edge();
            if (fin) break;
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL random_timeout got=busy exp=idle");
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        test_reset();
        test_stream();
        test_valid_toggle();
        test_abort();
        test_reset_settle();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
